parser_graph: RTL and testbench

- Parametrised packet-header parser. Walks a programmable header graph from header 0, fetching each header's next-tag field from packet memory and matching it against a per-header next table.
- Records the start address of every parsed header and flags which headers are present.
- Sits between packet buffer memory and the match-action stages.
- Generalises the two-header parser: N headers, M next-table entries, a memory ready handshake, depth and loop guards, and error reporting.

---
 rtl/parser_pkg.sv | 42 ++++
 rtl/parser_next_match.sv | 26 ++
 rtl/parser_graph.sv | 168 ++++++++++++++++
 tb/tb_parser_graph.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared types for the header-graph parser: FSM states, next-table entry layout, derived widths.
// Build option PARSER_TAG_MASK_EN adds a per-entry tag mask in the entry MSBs.
package parser_pkg;

  localparam int DEF_NUM_HDRS      = 8;
  localparam int DEF_NEXT_TBL_SIZE = 4;
  localparam int DEF_TAG_W         = 16;
  localparam int HID_W             = $clog2(DEF_NUM_HDRS);
  localparam int IDX_W             = $clog2(DEF_NEXT_TBL_SIZE);

  // Reported as next_id when nothing in the table matched.
  localparam logic [HID_W-1:0] NO_HDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    MATCH,
    DONE
  } state_t;

  // Field order matches cfg_entry_i so a config word can be cast directly.
  typedef struct packed {
`ifdef PARSER_TAG_MASK_EN
    logic [DEF_TAG_W-1:0] mask;
`endif
    logic                 vld;
    logic [DEF_TAG_W-1:0] tag;
    logic [HID_W-1:0]     next_id;
  } next_entry_t;

  localparam int ENTRY_W = $bits(next_entry_t);

  function automatic logic tag_hit(input next_entry_t e, input logic [DEF_TAG_W-1:0] t);
`ifdef PARSER_TAG_MASK_EN
    return ((t ^ e.tag) & e.mask) == '0;
`else
    return t == e.tag;
`endif
  endfunction

endpackage

// File: rtl/parser_next_match.sv
// Combinational priority matcher over one header's next table; lowest-index valid hit wins.
// Zero latency, no flow control.
module parser_next_match
  import parser_pkg::*;
#(
  parameter int NEXT_TBL_SIZE = DEF_NEXT_TBL_SIZE
) (
  input  next_entry_t [NEXT_TBL_SIZE-1:0] entries,
  input  logic [DEF_TAG_W-1:0]            tag,
  output logic                            hit,
  output logic [HID_W-1:0]                next_id
);

  // Scan from the top down so the lowest matching slot is the last to overwrite.
  always_comb begin
    hit     = 1'b0;
    next_id = NO_HDR;
    for (int i = NEXT_TBL_SIZE - 1; i >= 0; i--) begin
      if (entries[i].vld && tag_hit(entries[i], tag)) begin
        hit     = 1'b1;
        next_id = entries[i].next_id;
      end
    end
  end

endmodule

// File: rtl/parser_graph.sv
// Header-graph parser: walks headers from 0, fetching each next-tag from packet memory (>=3 cycles/header).
// Memory stalls via mem_rdy_i; config writes accepted only in IDLE. Option: PARSER_TAG_MASK_EN.
module parser_graph
  import parser_pkg::*;
#(
  parameter int NUM_HDRS      = DEF_NUM_HDRS,
  parameter int NEXT_TBL_SIZE = DEF_NEXT_TBL_SIZE,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int TAG_W         = DEF_TAG_W,
  parameter int MAX_DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          pkt_addr_i,
  output logic                       mem_ce_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [3:0]                 mem_width_o,
  input  logic                       mem_rdy_i,
  input  logic [DATA_W-1:0]          mem_data_i,
  output logic                       ready_o,
  output logic                       err_o,
  output logic [NUM_HDRS-1:0]        hdr_valid_o,
  output logic [NUM_HDRS*ADDR_W-1:0] parsed_hdrs_o,
  input  logic                       cfg_we_i,
  input  logic [HID_W-1:0]           cfg_hdr_id_i,
  input  logic [ADDR_W-1:0]          cfg_hdr_len_i,
  input  logic [ADDR_W-1:0]          cfg_tag_start_i,
  input  logic [3:0]                 cfg_tag_len_i,
  input  logic [IDX_W-1:0]           cfg_entry_idx_i,
  input  logic [ENTRY_W-1:0]         cfg_entry_i,
  output logic                       cfg_busy_o
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  state_t state, state_nxt;

  logic [ADDR_W-1:0]               hdr_len   [NUM_HDRS];
  logic [ADDR_W-1:0]               tag_start [NUM_HDRS];
  logic [3:0]                      tag_len   [NUM_HDRS];
  next_entry_t [NEXT_TBL_SIZE-1:0] next_tbl  [NUM_HDRS];
  logic [ADDR_W-1:0]               parsed    [NUM_HDRS];

  logic [ADDR_W-1:0]  base;
  logic [HID_W-1:0]   cur;
  logic [DEPTH_W-1:0] depth;
  logic [TAG_W-1:0]   tag;

  logic             hit;
  logic [HID_W-1:0] match_id;
  logic             loop_hit, depth_hit, advance;

  parser_next_match #(
    .NEXT_TBL_SIZE(NEXT_TBL_SIZE)
  ) u_match (
    .entries(next_tbl[cur]),
    .tag    (tag),
    .hit    (hit),
    .next_id(match_id)
  );

  assign loop_hit  = hit && hdr_valid_o[match_id];
  assign depth_hit = hit && (int'(depth) + 1 == MAX_DEPTH);
  assign advance   = hit && !loop_hit && !depth_hit;

  assign cfg_busy_o = (state != IDLE);

  for (genvar h = 0; h < NUM_HDRS; h++) begin : g_parsed
    assign parsed_hdrs_o[h*ADDR_W +: ADDR_W] = parsed[h];
  end

  // Only the right-aligned tag bits of the memory word are consumed.
  if (DATA_W > TAG_W) begin : g_unused
    logic unused_data_bits;
    assign unused_data_bits = ^mem_data_i[DATA_W-1:TAG_W];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!cfg_we_i && start_i) state_nxt = FETCH;
      FETCH:   state_nxt = (tag_len[cur] == '0) ? DONE : WAIT;
      WAIT:    if (mem_rdy_i) state_nxt = MATCH;
      MATCH:   state_nxt = advance ? FETCH : DONE;
      DONE:    if (!start_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ce_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_width_o <= '0;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      hdr_valid_o <= '0;
      base        <= '0;
      cur         <= '0;
      depth       <= '0;
      tag         <= '0;
      for (int h = 0; h < NUM_HDRS; h++) begin
        hdr_len[h]   <= '0;
        tag_start[h] <= '0;
        tag_len[h]   <= '0;
        next_tbl[h]  <= '0;
        parsed[h]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we_i) begin
            hdr_len[cfg_hdr_id_i]                    <= cfg_hdr_len_i;
            tag_start[cfg_hdr_id_i]                  <= cfg_tag_start_i;
            tag_len[cfg_hdr_id_i]                    <= cfg_tag_len_i;
            next_tbl[cfg_hdr_id_i][cfg_entry_idx_i]  <= next_entry_t'(cfg_entry_i);
          end else if (start_i) begin
            base        <= pkt_addr_i;
            cur         <= '0;
            depth       <= '0;
            hdr_valid_o <= '0;
            err_o       <= 1'b0;
            ready_o     <= 1'b0;
          end
        end
        FETCH: begin
          hdr_valid_o[cur] <= 1'b1;
          parsed[cur]      <= base;
          if (tag_len[cur] == '0) begin
            ready_o <= 1'b1;
          end else begin
            mem_ce_o    <= 1'b1;
            mem_addr_o  <= base + tag_start[cur];
            mem_width_o <= tag_len[cur];
          end
        end
        WAIT: begin
          if (mem_rdy_i) begin
            tag      <= mem_data_i[TAG_W-1:0];
            mem_ce_o <= 1'b0;
          end
        end
        MATCH: begin
          if (advance) begin
            base  <= base + hdr_len[cur];
            cur   <= match_id;
            depth <= depth + 1'b1;
          end else begin
            ready_o <= 1'b1;
            err_o   <= loop_hit || depth_hit;
          end
        end
        DONE: begin
          if (!start_i) ready_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_graph.sv
// Directed bench for parser_graph: a graph-walk model predicts requests and results for each parse.
module tb_parser_graph;

  localparam int AW   = 32;
  localparam int NH   = 8;
  localparam int NT   = 4;
  localparam int MAXD = 4;
`ifdef PARSER_TAG_MASK_EN
  localparam int EW = 16 + 1 + 16 + 3;
`else
  localparam int EW = 1 + 16 + 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start_i;
  logic [AW-1:0] pkt_addr_i;
  logic mem_ce_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0] mem_width_o;
  logic mem_rdy_i;
  logic [31:0] mem_data_i;
  logic ready_o, err_o;
  logic [NH-1:0] hdr_valid_o;
  logic [NH*AW-1:0] parsed_hdrs_o;
  logic cfg_we_i;
  logic [2:0] cfg_hdr_id_i;
  logic [AW-1:0] cfg_hdr_len_i, cfg_tag_start_i;
  logic [3:0] cfg_tag_len_i;
  logic [1:0] cfg_entry_idx_i;
  logic [EW-1:0] cfg_entry_i;
  logic cfg_busy_o;

  always #5 clk = ~clk;

  parser_graph #(.MAX_DEPTH(MAXD)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pkt_addr_i(pkt_addr_i),
    .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o), .mem_width_o(mem_width_o),
    .mem_rdy_i(mem_rdy_i), .mem_data_i(mem_data_i),
    .ready_o(ready_o), .err_o(err_o), .hdr_valid_o(hdr_valid_o), .parsed_hdrs_o(parsed_hdrs_o),
    .cfg_we_i(cfg_we_i), .cfg_hdr_id_i(cfg_hdr_id_i), .cfg_hdr_len_i(cfg_hdr_len_i),
    .cfg_tag_start_i(cfg_tag_start_i), .cfg_tag_len_i(cfg_tag_len_i),
    .cfg_entry_idx_i(cfg_entry_idx_i), .cfg_entry_i(cfg_entry_i), .cfg_busy_o(cfg_busy_o)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] pmem [0:4095];

  int          sh_len [NH];
  int          sh_ts  [NH];
  int          sh_tl  [NH];
  bit          sh_v   [NH][NT];
  logic [15:0] sh_tag [NH][NT];
  logic [15:0] sh_mask[NH][NT];
  int          sh_nid [NH][NT];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  width;
  } req_t;
  req_t req_q[$];

  logic [NH-1:0] exp_valid;
  logic          exp_err;
  logic [31:0]   exp_parsed [NH];

  int rdy_delay = 0;
  int wcnt      = 0;
  int nreq      = 0;
  bit armed     = 0;
  bit done_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a, input int w);
    logic [31:0] v = '0;
    for (int i = 0; i < w; i++) v = {v[23:0], pmem[12'(a + 32'(i))]};
    return v;
  endfunction

  task automatic poke16(input logic [31:0] a, input logic [15:0] v);
    pmem[12'(a)]          = v[15:8];
    pmem[12'(a + 32'd1)]  = v[7:0];
  endtask

  function automatic bit tag_ok(input logic [15:0] t, input int h, input int i);
`ifdef PARSER_TAG_MASK_EN
    return ((t ^ sh_tag[h][i]) & sh_mask[h][i]) == 16'h0;
`else
    return t == sh_tag[h][i];
`endif
  endfunction

  // Walk the configured graph from header 0 and list the expected reads.
  task automatic model(input logic [31:0] base0);
    int cur = 0;
    int depth = 0;
    int hit;
    logic [31:0] base = base0;
    logic [31:0] d;
    req_t r;
    exp_valid = '0;
    exp_err   = 1'b0;
    req_q.delete();
    forever begin
      exp_valid[cur]  = 1'b1;
      exp_parsed[cur] = base;
      if (sh_tl[cur] == 0) break;
      r.addr  = base + 32'(sh_ts[cur]);
      r.width = 4'(sh_tl[cur]);
      req_q.push_back(r);
      d = rd(r.addr, sh_tl[cur]);
      hit = -1;
      for (int i = 0; i < NT; i++) begin
        if (sh_v[cur][i] && tag_ok(d[15:0], cur, i)) begin
          hit = i;
          break;
        end
      end
      if (hit < 0) break;
      if (exp_valid[sh_nid[cur][hit]]) begin exp_err = 1'b1; break; end
      if (depth + 1 == MAXD) begin exp_err = 1'b1; break; end
      base  = base + 32'(sh_len[cur]);
      cur   = sh_nid[cur][hit];
      depth = depth + 1;
    end
  endtask

  task automatic clear_shadow();
    for (int h = 0; h < NH; h++) begin
      sh_len[h] = 0; sh_ts[h] = 0; sh_tl[h] = 0;
      for (int i = 0; i < NT; i++) begin
        sh_v[h][i] = 0; sh_tag[h][i] = '0; sh_mask[h][i] = '0; sh_nid[h][i] = 0;
      end
    end
  endtask

  task automatic cfg_write(input int h, input int len, input int ts, input int tl, input int idx,
                           input bit v, input logic [15:0] tag, input int nid,
                           input logic [15:0] mask, input bit shadow);
    @(posedge clk); #1;
    cfg_we_i        = 1'b1;
    cfg_hdr_id_i    = 3'(h);
    cfg_hdr_len_i   = 32'(len);
    cfg_tag_start_i = 32'(ts);
    cfg_tag_len_i   = 4'(tl);
    cfg_entry_idx_i = 2'(idx);
`ifdef PARSER_TAG_MASK_EN
    cfg_entry_i = {mask, v, tag, 3'(nid)};
`else
    cfg_entry_i = {v, tag, 3'(nid)};
`endif
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    if (shadow) begin
      sh_len[h] = len; sh_ts[h] = ts; sh_tl[h] = tl;
      sh_v[h][idx] = v; sh_tag[h][idx] = tag; sh_nid[h][idx] = nid; sh_mask[h][idx] = mask;
    end
  endtask

  task automatic parse(input logic [31:0] base, input int dly);
    int cyc = 0;
    model(base);
    rdy_delay = dly;
    nreq      = 0;
    done_seen = 0;
    armed     = 1;
    @(posedge clk); #1;
    pkt_addr_i = base;
    start_i    = 1'b1;
    while (!done_seen && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    chk("parse completes", done_seen, 1);
    armed = 0;
    #1;
    chk("ready held while start high", ready_o, 1);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("ready cleared", ready_o, 0);
    chk("idle after done", cfg_busy_o, 0);
  endtask

  // Memory responder: answers rdy_delay cycles after a request appears.
  initial forever begin
    @(posedge clk); #1;
    if (mem_ce_o && !rst) begin
      if (wcnt >= rdy_delay) begin
        mem_rdy_i  = 1'b1;
        mem_data_i = rd(mem_addr_o, int'(mem_width_o));
      end else begin
        mem_rdy_i  = 1'b0;
        mem_data_i = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      mem_rdy_i  = 1'b0;
      mem_data_i = 32'hDEAD_BEEF;
      wcnt       = 0;
    end
  end

  // Compare process: memory requests every cycle, results on completion.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (mem_ce_o) begin
        if (req_q.size() == 0) begin
          chk("spurious request", mem_ce_o, 0);
        end else begin
          chk("mem_addr", mem_addr_o, req_q[0].addr);
          chk("mem_width", mem_width_o, req_q[0].width);
          if (mem_rdy_i) begin
            void'(req_q.pop_front());
            nreq++;
          end
        end
      end
      if (ready_o && armed) begin
        armed     = 0;
        done_seen = 1;
        chk("hdr_valid", hdr_valid_o, exp_valid);
        chk("err", err_o, exp_err);
        chk("requests left", req_q.size(), 0);
        for (int h = 0; h < NH; h++)
          if (exp_valid[h]) chk("parsed addr", parsed_hdrs_o[h*AW +: AW], exp_parsed[h]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; start_i = 1'b0; pkt_addr_i = '0; cfg_we_i = 1'b0;
    cfg_hdr_id_i = '0; cfg_hdr_len_i = '0; cfg_tag_start_i = '0; cfg_tag_len_i = '0;
    cfg_entry_idx_i = '0; cfg_entry_i = '0; mem_rdy_i = 1'b0; mem_data_i = '0;
    for (int i = 0; i < 4096; i++) pmem[i] = 8'h00;
    clear_shadow();
    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_ce", mem_ce_o, 0);
    chk("reset ready", ready_o, 0);
    chk("reset err", err_o, 0);
    chk("reset hdr_valid", hdr_valid_o, 0);
    chk("reset busy", cfg_busy_o, 0);
    chk("reset mem_addr", mem_addr_o, 0);
    chk("reset mem_width", mem_width_o, 0);
    chk("reset parsed", parsed_hdrs_o[63:0], 0);
    rst = 1'b0;

    // Ethernet -> IPv4, memory answers one cycle late
    cfg_write(0, 14, 12, 2, 0, 1, 16'h0800, 1, 16'hFFFF, 1);
    cfg_write(1, 20, 0, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 1);
    poke16(32'h10C, 16'h0800);
    parse(32'h100, 1);
    chk("t1 hdr_valid", hdr_valid_o, 8'b11);
    chk("t1 parsed0", parsed_hdrs_o[31:0], 32'h100);
    chk("t1 parsed1", parsed_hdrs_o[63:32], 32'h10E);
    chk("t1 err", err_o, 0);
    chk("t1 reads", nreq, 1);

    // Unknown ethertype stops after header 0
    poke16(32'h10C, 16'h86DD);
    parse(32'h100, 0);
    chk("t2 hdr_valid", hdr_valid_o, 8'b01);
    chk("t2 err", err_o, 0);
    chk("t2 reads", nreq, 1);

    // hdr1 routes back to hdr0
    poke16(32'h10C, 16'h0800);
    cfg_write(1, 20, 0, 2, 0, 1, 16'hBEEF, 0, 16'hFFFF, 1);
    poke16(32'h10E, 16'hBEEF);
    parse(32'h100, 0);
    chk("t3 err", err_o, 1);
    chk("t3 hdr_valid", hdr_valid_o, 8'b11);
    chk("t3 reads", nreq, 2);

    // Long stall with a config write that must be dropped
    cfg_write(1, 20, 0, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 1);
    fork
      parse(32'h100, 12);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("busy during parse", cfg_busy_o, 1);
        cfg_write(0, 40, 12, 0, 0, 1, 16'h0800, 1, 16'hFFFF, 0);
      end
    join
    chk("t4 parsed1", parsed_hdrs_o[63:32], 32'h10E);
    parse(32'h100, 0);
    chk("t4 table untouched", hdr_valid_o, 8'b11);

    // Address wrap at the top of the space
    poke16(32'h4, 16'h0800);
    parse(32'hFFFF_FFF8, 2);
    chk("wrap parsed0", parsed_hdrs_o[31:0], 32'hFFFF_FFF8);
    chk("wrap parsed1", parsed_hdrs_o[63:32], 32'h6);

    // 8-header chain cut by the depth limit
    for (int h = 0; h < NH; h++) begin
      cfg_write(h, 16, 0, (h < NH - 1) ? 2 : 0, 0, (h < NH - 1), 16'(h + 1), (h + 1) % NH, 16'hFFFF, 1);
      poke16(32'h200 + 32'(16 * h), 16'(h + 1));
    end
    parse(32'h200, 0);
    chk("chain err", err_o, 1);
    chk("chain bits", $countones(hdr_valid_o), 4);
    chk("chain hdr_valid", hdr_valid_o, 8'h0F);
    chk("chain reads", nreq, 4);

    // Reset in the middle of a stalled read
    model(32'h300);
    rdy_delay = 100; armed = 0; done_seen = 0;
    @(posedge clk); #1;
    pkt_addr_i = 32'h300; start_i = 1'b1;
    cyc = 0;
    while (!mem_ce_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stall request raised", mem_ce_o, 1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("stall mem_addr", mem_addr_o, 32'h300);
      chk("stall mem_ce", mem_ce_o, 1);
    end
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst mem_ce", mem_ce_o, 0);
    chk("rst ready", ready_o, 0);
    chk("rst err", err_o, 0);
    chk("rst hdr_valid", hdr_valid_o, 0);
    chk("rst busy", cfg_busy_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst mem_width", mem_width_o, 0);
    chk("rst parsed", parsed_hdrs_o, 0);
    rst = 1'b0;
    req_q.delete();
    clear_shadow();

    // Cleared tables make header 0 terminal
    parse(32'h400, 0);
    chk("post-rst hdr_valid", hdr_valid_o, 8'b1);
    chk("post-rst parsed0", parsed_hdrs_o[31:0], 32'h400);
    chk("post-rst reads", nreq, 0);

    // Two entries hit; the lower slot wins
    cfg_write(0, 14, 12, 2, 0, 1, 16'h0800, 1, 16'hFFFF, 1);
    cfg_write(0, 14, 12, 2, 1, 1, 16'h1234, 2, 16'hFFFF, 1);
    cfg_write(0, 14, 12, 2, 2, 1, 16'h1234, 3, 16'hFFFF, 1);
    poke16(32'h50C, 16'h1234);
    parse(32'h500, 1);
    chk("prio hdr_valid", hdr_valid_o, 8'b101);
    chk("prio parsed2", parsed_hdrs_o[95:64], 32'h50E);

`ifdef PARSER_TAG_MASK_EN
    // Wildcard default route in the last slot
    cfg_write(0, 14, 12, 2, 3, 1, 16'h0000, 3, 16'h0000, 1);
    poke16(32'h50C, 16'h5555);
    parse(32'h500, 0);
    chk("mask hdr_valid", hdr_valid_o, 8'b1001);
    chk("mask parsed3", parsed_hdrs_o[127:96], 32'h50E);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
